// File: rtl/perf_counter_reader.sv
// perf_counter_reader
//   On a snapshot request, latches the whole performance counter set in one
//   cycle. The cycle counter (word 0) has the measurement overhead removed.
//   The block then streams the words in fixed order over a valid/ready
//   interface, each tagged with its index. An optional XOR checksum word
//   closes the frame.
//
// Ports
//   clk         clock, all state on rising edge
//   rst         asynchronous active-low reset
//   cnt_in      live counters, word k at [k*CNT_W +: CNT_W]
//   snap_req    snapshot request, sampled every cycle
//   out_valid   out_data/out_idx/out_last are valid
//   out_ready   consumer accepts the current word
//   out_data    current word
//   out_idx     index of current word (checksum uses index NUM_CNT)
//   out_last    current word ends the frame
//   busy        a frame is being streamed
//   drop_count  saturating count of requests ignored while busy
module perf_counter_reader #(
  parameter int NUM_CNT       = 9,
  parameter int CNT_W         = 32,
  parameter int CYCLE_ADJ     = 10,
  parameter int EMIT_CHECKSUM = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CNT*CNT_W-1:0] cnt_in,
  input  logic                     snap_req,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         out_data,
  output logic [3:0]               out_idx,
  output logic                     out_last,
  output logic                     busy,
  output logic [7:0]               drop_count
);

  localparam logic [3:0]       LAST_IDX = 4'(NUM_CNT - 1 + EMIT_CHECKSUM);
  localparam logic [CNT_W-1:0] ADJ      = CNT_W'(CYCLE_ADJ);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t           state;
  logic [CNT_W-1:0] shadow [NUM_CNT];
  logic [CNT_W-1:0] cks_q;

  logic [CNT_W-1:0] adj [NUM_CNT];
  logic [CNT_W-1:0] cks;
  logic [3:0]       next_idx;
  logic [CNT_W-1:0] next_data;

  // Adjusted view of the live counters and its checksum, consumed only on
  // the latch edge. The guard keeps word 0 from wrapping below zero.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    cks = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      adj[k] = cnt_in[k*CNT_W +: CNT_W];
      if (k == 0 && adj[k] > ADJ) adj[k] = adj[k] - ADJ;
      cks = cks ^ adj[k];
    end
  end

  // Word that follows the current one; index NUM_CNT selects the checksum.
  always_comb begin
    next_idx  = out_idx + 4'd1;
    next_data = cks_q;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (4'(k) == next_idx) next_data = shadow[k];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_idx    <= '0;
      out_data   <= '0;
      busy       <= 1'b0;
      drop_count <= '0;
      cks_q      <= '0;
      // NOTE: the shadow bank is small and must read as zero after reset, so
      // it is reset explicitly rather than left to power-up contents.
      for (int k = 0; k < NUM_CNT; k++) shadow[k] <= '0;
    end else begin
      // Requests during any streaming cycle, including the final transfer,
      // are dropped and counted.
      if (state == STREAM && snap_req && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;

      case (state)
        IDLE: begin
          if (snap_req) begin
            for (int k = 0; k < NUM_CNT; k++) shadow[k] <= adj[k];
            cks_q     <= cks;
            out_data  <= adj[0];
            out_idx   <= '0;
            out_last  <= (LAST_IDX == 4'd0);
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              out_idx  <= next_idx;
              out_data <= next_data;
              out_last <= (next_idx == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perf_counter_reader.sv
module tb_perf_counter_reader;

  localparam int NUM_CNT = 9;
  localparam int CNT_W   = 32;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CNT*CNT_W-1:0] cnt_in;
  logic                     snap_req;
  logic                     out_ready;

  logic             v1, l1, b1, v0, l0, b0;
  logic [CNT_W-1:0] d1, d0;
  logic [3:0]       i1, i0;
  logic [7:0]       dc1, dc0;

  perf_counter_reader dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .snap_req(snap_req),
    .out_valid(v1), .out_ready(out_ready), .out_data(d1), .out_idx(i1),
    .out_last(l1), .busy(b1), .drop_count(dc1)
  );

  perf_counter_reader #(.EMIT_CHECKSUM(0)) dut_nc (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .snap_req(snap_req),
    .out_valid(v0), .out_ready(out_ready), .out_data(d0), .out_idx(i0),
    .out_last(l0), .busy(b0), .drop_count(dc0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Instance 0 = with checksum (dut), instance 1 = without (dut_nc).
  // A frame is just a list of words; the model tracks which one is on offer.
  logic [31:0] m_frame [2][16];
  int          m_len   [2] = '{NUM_CNT + 1, NUM_CNT};
  int          m_idx   [2];
  bit          m_busy  [2];
  int          m_drop  [2];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 0; m_idx[i] = 0; m_drop[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_busy[i]) begin
          if (snap_req) begin
            logic [31:0] x, w;
            x = 0;
            for (int k = 0; k < NUM_CNT; k++) begin
              w = cnt_in[k*CNT_W +: CNT_W];
              if (k == 0 && w > 10) w = w - 10;
              m_frame[i][k] = w;
              x = x ^ w;
            end
            m_frame[i][NUM_CNT] = x;
            m_idx[i]  = 0;
            m_busy[i] = 1;
          end
        end else begin
          if (snap_req && m_drop[i] < 255) m_drop[i]++;
          if (out_ready) begin
            if (m_idx[i] == m_len[i] - 1) m_busy[i] = 0;
            else m_idx[i]++;
          end
        end
      end
    end
  end

  task automatic cmp(input int i, input logic v, input logic b, input logic l,
                     input logic [3:0] idx, input logic [31:0] d, input logic [7:0] dc);
    string t;
    t = (i == 0) ? "ck" : "nc";
    check({t, "_valid"}, 32'(v), 32'(m_busy[i]));
    check({t, "_busy"},  32'(b), 32'(m_busy[i]));
    check({t, "_drop"},  32'(dc), 32'(m_drop[i]));
    if (m_busy[i]) begin
      check({t, "_idx"},  32'(idx), 32'(m_idx[i]));
      check({t, "_data"}, d, m_frame[i][m_idx[i]]);
      check({t, "_last"}, 32'(l), 32'(m_idx[i] == m_len[i] - 1));
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      cmp(0, v1, b1, l1, i1, d1, dc1);
      cmp(1, v0, b0, l0, i0, d0, dc0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_words110();
    cnt_in[0 +: CNT_W] = 32'd110;
    for (int k = 1; k < NUM_CNT; k++) cnt_in[k*CNT_W +: CNT_W] = 32'(k);
  endtask

  task automatic rand_words();
    for (int k = 0; k < NUM_CNT; k++) cnt_in[k*CNT_W +: CNT_W] = $urandom;
    if ($urandom_range(0, 2) == 0) cnt_in[0 +: CNT_W] = 32'($urandom_range(0, 20));
  endtask

  task automatic pulse_snap();
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((v1 || v0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n < 50), 32'd1);
  endtask

  task automatic wait_idx(input logic [3:0] target);
    int n = 0;
    while (i1 != target && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("idx_timeout", 32'(n < 30), 32'd1);
  endtask

  task automatic adj_case(input logic [31:0] c0, input logic [31:0] exp);
    cnt_in[0 +: CNT_W] = c0;
    pulse_snap();
    check($sformatf("adj_%0d", c0), d1, exp);
    wait_idle();
  endtask

  initial begin
    int nv1, nv0, max0, n;

    rst = 1'b0; snap_req = 1'b0; out_ready = 1'b1; cnt_in = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(v1), 0);
    check("rst_last",  32'(l1), 0);
    check("rst_idx",   32'(i1), 0);
    check("rst_data",  d1, 0);
    check("rst_busy",  32'(b1), 0);
    check("rst_drop",  32'(dc1), 0);
    #2 rst = 1'b1;
    @(negedge clk);

    // Adjusted frame with hand-computed values.
    set_words110();
    pulse_snap();
    check("t1_latency", 32'(v1), 1);
    check("t1_word0", d1, 32'd100);
    nv1 = 0; nv0 = 0; max0 = 0;
    for (int c = 0; c < 20; c++) begin
      if (v1) begin
        nv1++;
        if (i1 == 4'd9) begin
          check("t1_checksum", d1, 32'd108);
          check("t1_last9", 32'(l1), 1);
        end else begin
          check("t1_notlast", 32'(l1), 0);
        end
      end
      if (v0) begin
        nv0++;
        if (32'(i0) > max0) max0 = 32'(i0);
        if (i0 == 4'd8) check("nc_last8", 32'(l0), 1);
      end
      @(negedge clk);
    end
    check("t1_valid_cycles", nv1, 10);
    check("nc_valid_cycles", nv0, 9);
    check("nc_max_idx", max0, 8);

    // Adjust boundary.
    set_words110();
    adj_case(32'd10, 32'd10);
    adj_case(32'd11, 32'd1);
    adj_case(32'd0,  32'd0);

    // Backpressure on idx 4.
    set_words110();
    pulse_snap();
    wait_idx(4'd4);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_valid", 32'(v1), 1);
      check("bp_idx", 32'(i1), 4);
      check("bp_data", d1, 4);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_resume_idx", 32'(i1), 5);
    check("bp_resume_data", d1, 5);
    wait_idle();

    // Frozen snapshot plus dropped requests.
    set_words110();
    pulse_snap();
    rand_words();
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      pulse_snap();
      @(negedge clk);
    end
    check("drop3", 32'(dc1), 3);
    n = 0;
    while (!l1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("last_timeout", 32'(n < 20), 1);
    check("busy_on_last", 32'(b1), 1);
    @(negedge clk);
    check("busy_after_last", 32'(b1), 0);
    wait_idle();

    // Asynchronous reset mid-frame.
    set_words110();
    pulse_snap();
    wait_idx(4'd6);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 32'(v1), 0);
    check("arst_busy",  32'(b1), 0);
    check("arst_drop",  32'(dc1), 0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    pulse_snap();
    check("arst_restart_valid", 32'(v1), 1);
    check("arst_restart_idx", 32'(i1), 0);
    check("arst_restart_data", d1, 100);
    wait_idle();

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      snap_req  = ($urandom_range(0, 5) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      rand_words();
      @(negedge clk);
    end
    snap_req  = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
